// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: state codes,
// control-word field positions, instruction-class codes and the fetch word.
package cu_pkg;

    localparam int CU_CUL = 36;

    typedef enum logic [3:0] {
        ST_IF   = 4'b0000,
        ST_EX0  = 4'b0001,
        ST_EX1  = 4'b0010,
        ST_EX2  = 4'b0011,
        ST_EX3  = 4'b0100,
        ST_HALT = 4'b1111
    } state_e;

    localparam int CW_PC_FS_LSB     = 0;
    localparam int CW_PC_SEL        = 2;
    localparam int CW_DATA_TRI_LSB  = 3;
    localparam int CW_ADD_TRI_SEL   = 5;
    localparam int CW_SIZE_LSB      = 6;
    localparam int CW_STATUS_LOAD   = 8;
    localparam int CW_IR_LOAD       = 9;
    localparam int CW_MEM_WRITE_EN  = 10;
    localparam int CW_B_SEL         = 11;
    localparam int CW_MEM_CS_LSB    = 12;
    localparam int CW_C0            = 14;
    localparam int CW_W_REG         = 15;
    localparam int CW_DA_LSB        = 16;
    localparam int CW_SB_LSB        = 21;
    localparam int CW_SA_LSB        = 26;
    localparam int CW_FS_LSB        = 31;

    // One-hot class select {br, di, dr, ls, illegal}
    localparam logic [4:0] CLS_BR  = 5'b10000;
    localparam logic [4:0] CLS_DI  = 5'b01000;
    localparam logic [4:0] CLS_DR  = 5'b00100;
    localparam logic [4:0] CLS_LS  = 5'b00010;
    localparam logic [4:0] CLS_ILL = 5'b00001;

    // mem_cs=01, IR_load=1, add_tri_sel=1, PC held; only the low 16 bits are ever set
    localparam logic [15:0] FETCH_WORD = (16'd1 << CW_MEM_CS_LSB)
                                       | (16'd1 << CW_IR_LOAD)
                                       | (16'd1 << CW_ADD_TRI_SEL);

    function automatic logic ns_legal(input logic [3:0] ns);
        return ns <= ST_EX3;
    endfunction

endpackage

// File: rtl/cu_class_decode.sv
// Instruction-class decode from IR[28:25] to a one-hot class select.
module cu_class_decode
    import cu_pkg::*;
(
    input  logic [3:0] op,
    output logic [4:0] cls
);

    always_comb begin
        cls = CLS_ILL;
        if (op[3:1] == 3'b101) begin
            cls = CLS_BR;
        end else if (op[3:1] == 3'b100) begin
            cls = CLS_DI;
        end else if (op[2:0] == 3'b101) begin
            cls = CLS_DR;
        end else if (op[2] && !op[0]) begin
            cls = CLS_LS;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: state/IR/status registers, fetch handshake with
// memory, and selection of the active class decoder's next state and word.
//
// state | meaning
// IF    | fetch: request instruction, load IR on mem_ready
// EX0-3 | execute: next state and word come from the class decoder
// HALT  | illegal opcode/state or fetch timeout; left only by reset
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int CUL           = CU_CUL,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           run,
    input  logic           mem_ready,
    input  logic [31:0]    data_bus,
    input  logic [3:0]     alu_flags,
    input  logic [3:0]     ns_br,
    input  logic [3:0]     ns_di,
    input  logic [3:0]     ns_dr,
    input  logic [3:0]     ns_ls,
    input  logic [CUL:0]   cw_br,
    input  logic [CUL:0]   cw_di,
    input  logic [CUL:0]   cw_dr,
    input  logic [CUL:0]   cw_ls,
    output logic [3:0]     state,
    output logic [31:0]    IR,
    output logic [3:0]     status,
    output logic [CUL:0]   controlWord,
    output logic           illegal,
    output logic           bus_error,
    output logic [31:0]    retired
);

    localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [3:0]          status_q, status_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                illegal_q, illegal_d;
    logic                bus_error_q, bus_error_d;
    logic [31:0]         retired_q, retired_d;

    logic [4:0]          cls;
    logic [3:0]          sel_ns;
    logic [CUL:0]        sel_cw;
    logic                sel_ok;
    logic [CUL:0]        fetch_cw;
    logic [CUL:0]        cw;
    logic                fetch_req;

    cu_class_decode u_class_decode (
        .op  (ir_q[28:25]),
        .cls (cls)
    );

    always_comb begin
        sel_ns = ST_IF;
        sel_cw = '0;
        sel_ok = 1'b1;
        case (cls)
            CLS_BR:  begin sel_ns = ns_br; sel_cw = cw_br; end
            CLS_DI:  begin sel_ns = ns_di; sel_cw = cw_di; end
            CLS_DR:  begin sel_ns = ns_dr; sel_cw = cw_dr; end
            CLS_LS:  begin sel_ns = ns_ls; sel_cw = cw_ls; end
            default: sel_ok = 1'b0;
        endcase
    end

    // A fetch that has started keeps going even if run drops
    assign fetch_req = run || (wait_q != '0);

    always_comb begin
        fetch_cw       = '0;
        fetch_cw[15:0] = FETCH_WORD;
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        status_d    = status_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        retired_d   = retired_q;
        cw          = '0;

        case (state_q)
            ST_IF: begin
                if (fetch_req) begin
                    cw = fetch_cw;
                    if (mem_ready) begin
                        cw[CW_PC_FS_LSB] = 1'b1;
                        ir_d             = data_bus;
                        wait_d           = '0;
                        state_d          = ST_EX0;
                    end else if (wait_q == WAIT_W'(FETCH_TIMEOUT - 1)) begin
                        wait_d      = '0;
                        bus_error_d = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            ST_EX0, ST_EX1, ST_EX2, ST_EX3: begin
                if (!sel_ok || !ns_legal(sel_ns)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    cw      = sel_cw;
                    cw[CUL] = 1'b0;
                    state_d = state_e'(sel_ns);
                    if (sel_ns == ST_IF) begin
                        retired_d = retired_q + 32'd1;
                    end
                end
            end
            ST_HALT: begin
            end
            default: state_d = ST_HALT;
        endcase

        if (cw[CW_STATUS_LOAD]) begin
            status_d = alu_flags;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IF;
            ir_q        <= '0;
            status_q    <= '0;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            status_q    <= status_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

    assign state       = state_q;
    assign IR          = ir_q;
    assign status      = status_q;
    assign controlWord = reset ? cw : '0;
    assign illegal     = illegal_q;
    assign bus_error   = bus_error_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cu_sequencer;

    localparam logic [3:0]  S_IF   = 4'h0;
    localparam logic [3:0]  S_EX0  = 4'h1;
    localparam logic [3:0]  S_EX1  = 4'h2;
    localparam logic [3:0]  S_EX2  = 4'h3;
    localparam logic [3:0]  S_EX3  = 4'h4;
    localparam logic [3:0]  S_HALT = 4'hF;
    localparam logic [36:0] CW0    = 37'h0;
    localparam logic [36:0] FW     = 37'h1220;
    localparam logic [36:0] FW1    = 37'h1221;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] data_bus = '0;
    logic [3:0]  alu_flags = '0;
    logic [3:0]  ns_br = '0, ns_di = '0, ns_dr = '0, ns_ls = '0;
    logic [36:0] cw_br = '0, cw_di = '0, cw_dr = '0, cw_ls = '0;
    logic [3:0]  state;
    logic [31:0] IR;
    logic [3:0]  status;
    logic [36:0] controlWord;
    logic        illegal;
    logic        bus_error;
    logic [31:0] retired;

    cu_sequencer #(.CUL(36), .FETCH_TIMEOUT(255)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .mem_ready   (mem_ready),
        .data_bus    (data_bus),
        .alu_flags   (alu_flags),
        .ns_br       (ns_br),
        .ns_di       (ns_di),
        .ns_dr       (ns_dr),
        .ns_ls       (ns_ls),
        .cw_br       (cw_br),
        .cw_di       (cw_di),
        .cw_dr       (cw_dr),
        .cw_ls       (cw_ls),
        .state       (state),
        .IR          (IR),
        .status      (status),
        .controlWord (controlWord),
        .illegal     (illegal),
        .bus_error   (bus_error),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [3:0]  st;
        logic [36:0] cw;
        logic [31:0] ir;
        logic [3:0]  stat;
        logic        ill;
        logic        berr;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   next_id = 0;
    exp_t mon_e;

    task automatic chk(input int id, input string nm, input logic [36:0] got, input logic [36:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, id, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.id, "state",     {33'b0, state},       {33'b0, mon_e.st});
            chk(mon_e.id, "cw",        controlWord,          mon_e.cw);
            chk(mon_e.id, "IR",        {5'b0, IR},           {5'b0, mon_e.ir});
            chk(mon_e.id, "status",    {33'b0, status},      {33'b0, mon_e.stat});
            chk(mon_e.id, "illegal",   {36'b0, illegal},     {36'b0, mon_e.ill});
            chk(mon_e.id, "bus_error", {36'b0, bus_error},   {36'b0, mon_e.berr});
            chk(mon_e.id, "retired",   {5'b0, retired},      {5'b0, mon_e.ret});
        end
    end

    task automatic expect_c(input logic [3:0] st, input logic [36:0] cw, input logic [31:0] ir,
                            input logic [3:0] stat, input logic ill, input logic berr, input logic [31:0] ret);
        exp_t e;
        e.id = next_id; e.st = st; e.cw = cw; e.ir = ir; e.stat = stat;
        e.ill = ill; e.berr = berr; e.ret = ret;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset is held across two edges with the fetch inputs active to show they are ignored
    task automatic do_reset();
        reset = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        expect_c(S_IF, CW0, 32'h0, 4'h0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog vec=%0d got=running want=finished", next_id);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        do_reset();

        // unconditional branch, single EX cycle
        run = 1; mem_ready = 1; data_bus = 32'h14000004; ns_br = 4'h0; cw_br = 37'h3;
        expect_c(S_IF, FW1, 32'h0, 4'h0, 0, 0, 0); tick();
        expect_c(S_EX0, 37'h3, 32'h14000004, 4'h0, 0, 0, 0); tick();
        run = 0;
        expect_c(S_IF, CW0, 32'h14000004, 4'h0, 0, 0, 1); tick();

        // two-cycle branch with status load in EX0, reserved bit 36 masked in EX1
        run = 1; mem_ready = 1; data_bus = 32'hB4000123;
        expect_c(S_IF, FW1, 32'h14000004, 4'h0, 0, 0, 1); tick();
        ns_br = 4'h2; cw_br = 37'h0_8000_0100; alu_flags = 4'b0001;
        expect_c(S_EX0, 37'h0_8000_0100, 32'hB4000123, 4'h0, 0, 0, 1); tick();
        ns_br = 4'h0; cw_br = 37'h10_0000_0003; alu_flags = 4'b1111;
        expect_c(S_EX1, 37'h3, 32'hB4000123, 4'b0001, 0, 0, 1); tick();
        run = 0; mem_ready = 0;
        expect_c(S_IF, CW0, 32'hB4000123, 4'b0001, 0, 0, 2); tick();

        // fetch waits three cycles, run drops mid-fetch; data-register class via EX2
        data_bus = 32'h0A000000; ns_dr = 4'h3; cw_dr = 37'h8000; run = 1; mem_ready = 0;
        expect_c(S_IF, FW, 32'hB4000123, 4'b0001, 0, 0, 2); tick();
        run = 0;
        expect_c(S_IF, FW, 32'hB4000123, 4'b0001, 0, 0, 2); tick();
        expect_c(S_IF, FW, 32'hB4000123, 4'b0001, 0, 0, 2); tick();
        mem_ready = 1;
        expect_c(S_IF, FW1, 32'hB4000123, 4'b0001, 0, 0, 2); tick();
        mem_ready = 0;
        expect_c(S_EX0, 37'h8000, 32'h0A000000, 4'b0001, 0, 0, 2); tick();
        ns_dr = 4'h0; cw_dr = 37'h8100; alu_flags = 4'b1010;
        expect_c(S_EX2, 37'h8100, 32'h0A000000, 4'b0001, 0, 0, 2); tick();
        expect_c(S_IF, CW0, 32'h0A000000, 4'b1010, 0, 0, 3); tick();

        // data-immediate interrupted by reset in EX1
        data_bus = 32'h10000000; run = 1; mem_ready = 1; ns_di = 4'h2; cw_di = 37'h40;
        expect_c(S_IF, FW1, 32'h0A000000, 4'b1010, 0, 0, 3); tick();
        expect_c(S_EX0, 37'h40, 32'h10000000, 4'b1010, 0, 0, 3); tick();
        ns_di = 4'h0; cw_di = 37'h41;
        expect_c(S_EX1, 37'h41, 32'h10000000, 4'b1010, 0, 0, 3);
        @(negedge clock);
        #1;
        do_reset();

        run = 1; mem_ready = 1; data_bus = 32'h14000004; ns_br = 4'h0; cw_br = 37'h3;
        expect_c(S_IF, FW1, 32'h0, 4'h0, 0, 0, 0); tick();
        expect_c(S_EX0, 37'h3, 32'h14000004, 4'h0, 0, 0, 0); tick();
        run = 0;
        expect_c(S_IF, CW0, 32'h14000004, 4'h0, 0, 0, 1); tick();

        // load/store class through EX3
        run = 1; mem_ready = 1; data_bus = 32'h0C000000; ns_ls = 4'h4; cw_ls = 37'h1000;
        expect_c(S_IF, FW1, 32'h14000004, 4'h0, 0, 0, 1); tick();
        expect_c(S_EX0, 37'h1000, 32'h0C000000, 4'h0, 0, 0, 1); tick();
        ns_ls = 4'h0; cw_ls = 37'h1400;
        expect_c(S_EX3, 37'h1400, 32'h0C000000, 4'h0, 0, 0, 1); tick();
        run = 0;
        expect_c(S_IF, CW0, 32'h0C000000, 4'h0, 0, 0, 2); tick();

        // illegal class: no status load, HALT ignores run
        run = 1; mem_ready = 1; data_bus = 32'h00000000; alu_flags = 4'b0110;
        ns_br = 4'h0; ns_di = 4'h0; ns_dr = 4'h0; ns_ls = 4'h0;
        cw_br = 37'h100; cw_di = 37'h100; cw_dr = 37'h100; cw_ls = 37'h100;
        expect_c(S_IF, FW1, 32'h0C000000, 4'h0, 0, 0, 2); tick();
        expect_c(S_EX0, CW0, 32'h0, 4'h0, 0, 0, 2); tick();
        for (int i = 0; i < 3; i++) begin
            run = ~run;
            expect_c(S_HALT, CW0, 32'h0, 4'h0, 1, 0, 2); tick();
        end
        do_reset();

        // decoder returns an undefined state code
        run = 1; mem_ready = 1; data_bus = 32'h08000000; ns_ls = 4'h7; cw_ls = 37'h3000;
        expect_c(S_IF, FW1, 32'h0, 4'h0, 0, 0, 0); tick();
        expect_c(S_EX0, CW0, 32'h08000000, 4'h0, 0, 0, 0); tick();
        expect_c(S_HALT, CW0, 32'h08000000, 4'h0, 1, 0, 0); tick();
        do_reset();

        // ready arrives on the 255th wait cycle: fetch succeeds
        run = 1; mem_ready = 0; data_bus = 32'h14000004; ns_br = 4'h0; cw_br = 37'h3;
        for (int i = 0; i < 254; i++) begin
            expect_c(S_IF, FW, 32'h0, 4'h0, 0, 0, 0); tick();
        end
        mem_ready = 1;
        expect_c(S_IF, FW1, 32'h0, 4'h0, 0, 0, 0); tick();
        mem_ready = 0;
        expect_c(S_EX0, 37'h3, 32'h14000004, 4'h0, 0, 0, 0); tick();

        // ready never arrives: bus error after 255 wait cycles
        for (int i = 0; i < 255; i++) begin
            expect_c(S_IF, FW, 32'h14000004, 4'h0, 0, 0, 1); tick();
        end
        expect_c(S_HALT, CW0, 32'h14000004, 4'h0, 0, 1, 1); tick();
        mem_ready = 1;
        expect_c(S_HALT, CW0, 32'h14000004, 4'h0, 0, 1, 1); tick();

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0 pending", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Top-level sequencer of the multicycle control unit: owns the state register, the instruction register and the status-flag register, and runs the instruction-fetch handshake with memory. It broadcasts `state`, `IR` and `status` to the class decoders (branch, data-immediate, data-register, load/store). It then selects the active decoder's next state and control word and drives the datapath. It also generates the fetch control word itself and flags illegal opcodes and fetch timeouts.

## Interface
- `CUL`, 36: MSB index of the control word (word is CUL+1 bits).
- `FETCH_TIMEOUT`, 255: maximum `mem_ready` wait cycles in fetch before `bus_error`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  permits a new fetch to start.
- `mem_ready`  in  1  memory read data valid this cycle.
- `data_bus`  in  32  memory read data (instruction word).
- `alu_flags`  in  4  {V,C,N,Z} from the ALU.
- `ns_br`, `ns_di`, `ns_dr`, `ns_ls`  in  4 each  next state from each class decoder.
- `cw_br`, `cw_di`, `cw_dr`, `cw_ls`  in  CUL+1 each  control word from each class decoder.
- `state`  out  4  current state to the decoders.
- `IR`  out  32  instruction register.
- `status`  out  4  registered {V,C,N,Z}.
- `controlWord`  out  CUL+1  word driven to the datapath.
- `illegal`  out  1  sticky: unrecognised opcode decoded.
- `bus_error`  out  1  sticky: fetch timed out.
- `retired`  out  32  count of completed instructions.

## Operation
- Control-word field map, from the LSB:
  - PC_FS[1:0], PC_sel[2], data_tri_sel[4:3], add_tri_sel[5], size[7:6], status_load[8], IR_load[9], mem_write_en[10], B_Sel[11], mem_cs[13:12], C0[14], w_reg[15], DA[20:16], SB[25:21], SA[30:26], FS[35:31].
  - Bit 36 is reserved and always 0.
- States (4-bit encoding):
  - IF = 0000
  - EX0 = 0001, EX1 = 0010, EX2 = 0011, EX3 = 0100 (owned by the decoders)
  - HALT = 1111
- Class select is decoded from `IR[28:25]`:
  - 101x → branch (`br`)
  - 100x → data-immediate (`di`)
  - x101 → data-register (`dr`)
  - x1x0 → load/store (`ls`)
  - Anything else → illegal.
- IF, `run`=0:
  - controlWord = all zero (PC_FS=00, hold).
  - Stay in IF.
- IF, `run`=1, `mem_ready`=0:
  - Fetch word: mem_cs=01, add_tri_sel=1, IR_load=1, PC_FS=00, all other bits 0.
  - Increment the wait counter.
- IF, `run`=1, `mem_ready`=1:
  - Same fetch word, but PC_FS=01 (PC+4).
  - At the clock edge: IR <= `data_bus`; clear the wait counter; state <= EX0.
- Wait counter reaches FETCH_TIMEOUT (while still in IF, `mem_ready`=0):
  - Set `bus_error`; state <= HALT.
- EX states:
  - controlWord = the selected class word.
  - state <= the selected class `ns_*`.
  - If that next state is IF, increment `retired` at the same edge.
- EX0 with an illegal class:
  - controlWord = zero; set `illegal`; state <= HALT.
- Decoder returns 1111 or an undefined EX code (0101–1110):
  - Treat as illegal: set `illegal`; state <= HALT.
- status:
  - status <= `alu_flags` at any edge where the driven controlWord has status_load=1.
  - Otherwise hold.
- HALT:
  - controlWord = zero.
  - Held until reset; `run` is ignored.
- `retired` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous, immediate) values: state=IF, IR=0, status=0, wait counter=0, illegal=0, bus_error=0, retired=0.
- Outputs while in reset: controlWord=0.
- controlWord is combinational from the registered state/IR and the decoder inputs; no registered output delay.
- Fetch latency: one cycle minimum (`mem_ready` high in the first IF cycle) → EX0 on the next edge.
- A branch completing in EX0 (decoder NS=IF) returns to IF one edge later; a cycle of IF follows every instruction.
- `mem_ready` is ignored outside IF.
- `mem_ready`=1 on the same cycle the counter hits FETCH_TIMEOUT: the fetch succeeds; no error.
- `run` dropping mid-fetch (IF with the request outstanding): the fetch continues until `mem_ready` or timeout.
- Reset asserted mid-instruction: immediate return to IF; any partial instruction is discarded and not counted.

## Structure
- Shared package `cu_pkg`:
  - State encodings (IF, EX0–EX3, HALT).
  - Control-word field bit positions and the CUL constant.
  - Class codes.
  - FETCH_WORD constant.
- One sub-module: `cu_class_decode`, combinational IR[28:25] → one-hot {br, di, dr, ls, illegal}.
- Everything else is flat in `cu_sequencer`.

## Test plan
- Reset, `run`=1, `mem_ready`=1, `data_bus`=0x14000004 (B), `ns_br`=0000 → IR=0x14000004; state sequence IF→EX0→IF; `retired`=1; PC_FS=01 only in the IF cycle.
- CBZ fetched, `ns_br`=0010 then 0000, `cw_br` with status_load=1 in EX0, `alu_flags`=0001 → status=0001 after EX0; `retired` increments at the EX1→IF edge.
- `mem_ready` held low for 3 cycles then high → 4 IF cycles with mem_cs=01 and PC_FS=00,00,00,01; EX0 follows.
- `mem_ready` never high, FETCH_TIMEOUT=255 → `bus_error`=1 and state=HALT after the 255th wait cycle; controlWord=0 thereafter.
- IR[28:25]=0000 → `illegal`=1, state HALT from EX0; `run` toggling has no effect; reset low clears to IF.
- Reset asserted during EX1 → state=IF, IR=0, `retired` unchanged at 0; the next fetch behaves normally.
